// File: rtl/pll_lock_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_lock_seq_pkg;

   // Encoding is visible on state_dbg, so the values are pinned explicitly.
   typedef enum logic [2:0] {
      RST_PLL   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      GATE      = 3'd3,
      RELEASE   = 3'd4,
      RUN       = 3'd5,
      FAIL      = 3'd6
   } seq_state_e;

   // One extra bit so the largest load value itself fits (e.g. 65536 needs 17 bits).
   function automatic int ctr_width(input int rst_hold, input int stable_cyc,
                                    input int timeout_cyc, input int gate_cyc,
                                    input int stagger_cyc);
      int m;
      m = rst_hold;
      if (stable_cyc  > m) m = stable_cyc;
      if (timeout_cyc > m) m = timeout_cyc;
      if (gate_cyc    > m) m = gate_cyc;
      if (stagger_cyc > m) m = stagger_cyc;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pll_lock_seq_sync.sv
// Two-flop synchroniser bringing the raw PLL LOCK into the clkin1 domain.
module pll_lock_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   // Two flops in series; the first may go metastable, the second settles it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: core reset pulse, lock wait/filter, clock gate enable,
// staggered channel reset release, lock-loss recovery with bounded retries.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   RST_PLL   | PLL core reset held high; counter counts up to the hold
//   WAIT_LOCK | core reset released, waiting for lock with timeout
//   STABLE    | lock seen, must stay high for the full filter window
//   GATE      | CLKOUT0 gate enabled, waiting before first channel release
//   RELEASE   | channel resets cleared one by one, LSB first
//   RUN       | all channels running, ready high
//   FAIL      | retries exhausted; everything held in reset until restart
module pll_lock_seq
   import pll_lock_seq_pkg::*;
#(
   parameter int N_CH             = 5,
   parameter int RST_HOLD_CYC     = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int GATE_DELAY_CYC   = 8,
   parameter int STAGGER_CYC      = 4,
   parameter int MAX_RETRY        = 3
) (
   input  logic            clkin1,
   input  logic            pll_rst,
   input  logic            pll_lock,
   input  logic            restart,
   output logic            pll_core_rst,
   output logic            clkout0_gate,
   output logic [N_CH-1:0] ch_rst,
   output logic            ready,
   output logic            fail,
   output logic [7:0]      retry_cnt,
   output logic [2:0]      state_dbg
);

   localparam int CW = ctr_width(RST_HOLD_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC,
                                 GATE_DELAY_CYC, STAGGER_CYC);
   localparam logic [CW-1:0]   HOLD_LAST  = CW'(RST_HOLD_CYC - 1);
   localparam logic [CW-1:0]   TIMEOUT_LD = CW'(LOCK_TIMEOUT_CYC);
   localparam logic [CW-1:0]   STABLE_LD  = CW'(LOCK_STABLE_CYC);
   localparam logic [CW-1:0]   GATE_LD    = CW'(GATE_DELAY_CYC);
   localparam logic [CW-1:0]   STAGGER_LD = CW'(STAGGER_CYC);
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
   localparam logic [N_CH-1:0] CH_ALL     = {N_CH{1'b1}};

   seq_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            core_rst_q, core_rst_d;
   logic            gate_q, gate_d;
   logic [N_CH-1:0] ch_rst_q, ch_rst_d;
   logic            ready_q, ready_d;
   logic            fail_q, fail_d;
   logic [7:0]      retry_q, retry_d;
   logic            lock_s;
   logic            cnt_expired;
   logic            attempt_fail;

   pll_lock_sync u_sync (
      .clk_i (clkin1),
      .rst_i (pll_rst),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

   // A phase loaded with L lasts exactly L cycles: expiry is seen on the last one.
   assign cnt_expired = (cnt_q <= CNT_ONE);

   // Next state, counter and the registered output values.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ch_rst_d     = ch_rst_q;
      fail_d       = fail_q;
      retry_d      = retry_q;
      attempt_fail = 1'b0;

      unique case (state_q)
         // Counts up from 0 so the hold starts cleanly straight out of reset.
         RST_PLL: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = TIMEOUT_LD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = STABLE_LD;
            end else if (cnt_expired) begin
               attempt_fail = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         // A dropout while filtering is not a failed attempt, just a fresh wait.
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = TIMEOUT_LD;
            end else if (cnt_expired) begin
               state_d = GATE;
               cnt_d   = GATE_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         GATE: begin
            if (!lock_s) begin
               attempt_fail = 1'b1;
            end else if (cnt_expired) begin
               state_d  = RELEASE;
               cnt_d    = STAGGER_LD;
               ch_rst_d = CH_ALL << 1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         // ch_rst itself tracks progress: zeros are shifted in from the LSB.
         RELEASE: begin
            if (!lock_s) begin
               attempt_fail = 1'b1;
            end else if (!ch_rst_q[N_CH-1]) begin
               state_d = RUN;
            end else if (cnt_expired) begin
               ch_rst_d = ch_rst_q << 1;
               cnt_d    = STAGGER_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RUN: begin
            if (!lock_s) begin
               attempt_fail = 1'b1;
            end
         end
         FAIL: begin
         end
         default: begin
            state_d = RST_PLL;
            cnt_d   = '0;
         end
      endcase

      if (attempt_fail) begin
         retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
         cnt_d   = '0;
         if ((MAX_RETRY != 0) && (int'(retry_q) + 1 >= MAX_RETRY)) begin
            state_d = FAIL;
            fail_d  = 1'b1;
         end else begin
            state_d = RST_PLL;
         end
      end

      if (restart) begin
         state_d = RST_PLL;
         cnt_d   = '0;
         fail_d  = 1'b0;
         retry_d = '0;
      end

      if ((state_d != RELEASE) && (state_d != RUN)) begin
         ch_rst_d = CH_ALL;
      end
      core_rst_d = (state_d == RST_PLL) || (state_d == FAIL);
      gate_d     = (state_d == GATE) || (state_d == RELEASE) || (state_d == RUN);
      ready_d    = (state_d == RUN);
   end

   // State, counter and output registers.
   always_ff @(posedge clkin1 or posedge pll_rst) begin
      if (pll_rst) begin
         state_q    <= RST_PLL;
         cnt_q      <= '0;
         core_rst_q <= 1'b1;
         gate_q     <= 1'b0;
         ch_rst_q   <= CH_ALL;
         ready_q    <= 1'b0;
         fail_q     <= 1'b0;
         retry_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         core_rst_q <= core_rst_d;
         gate_q     <= gate_d;
         ch_rst_q   <= ch_rst_d;
         ready_q    <= ready_d;
         fail_q     <= fail_d;
         retry_q    <= retry_d;
      end
   end

   assign pll_core_rst = core_rst_q;
   assign clkout0_gate = gate_q;
   assign ch_rst       = ch_rst_q;
   assign ready        = ready_q;
   assign fail         = fail_q;
   assign retry_cnt    = retry_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: phase/elapsed-time reference model checked every
// cycle, plus hand-computed cycle pins for the directed scenarios.
module tb_pll_lock_seq;

   localparam int N_CH       = 5;
   localparam int RST_HOLD   = 16;
   localparam int STABLE_CYC = 64;
   localparam int TIMEOUT    = 200;
   localparam int GATE_DLY   = 8;
   localparam int STAGGER    = 4;
   localparam int MAX_RETRY  = 3;

   localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_GATE = 3,
                  P_REL = 4, P_RUN = 5, P_FAIL = 6;

   logic            clkin1   = 1'b0;
   logic            pll_rst  = 1'b0;
   logic            pll_lock = 1'b0;
   logic            restart  = 1'b0;
   logic            pll_core_rst;
   logic            clkout0_gate;
   logic [N_CH-1:0] ch_rst;
   logic            ready;
   logic            fail;
   logic [7:0]      retry_cnt;
   logic [2:0]      state_dbg;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model: phase, cycles spent in it, and a raw lock history
   int m_phase = P_RST;
   int m_el    = 0;
   int m_retry = 0;
   bit m_fail  = 1'b0;
   bit lhist [2];

   pll_lock_seq #(
      .N_CH             (N_CH),
      .RST_HOLD_CYC     (RST_HOLD),
      .LOCK_STABLE_CYC  (STABLE_CYC),
      .LOCK_TIMEOUT_CYC (TIMEOUT),
      .GATE_DELAY_CYC   (GATE_DLY),
      .STAGGER_CYC      (STAGGER),
      .MAX_RETRY        (MAX_RETRY)
   ) dut (
      .clkin1       (clkin1),
      .pll_rst      (pll_rst),
      .pll_lock     (pll_lock),
      .restart      (restart),
      .pll_core_rst (pll_core_rst),
      .clkout0_gate (clkout0_gate),
      .ch_rst       (ch_rst),
      .ready        (ready),
      .fail         (fail),
      .retry_cnt    (retry_cnt),
      .state_dbg    (state_dbg)
   );

   always #5 clkin1 = ~clkin1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
      end
   endtask

   // Channels still in reset: all in early phases, none in RUN, and during
   // release one more LSB cleared every STAGGER cycles starting at entry.
   function automatic int exp_ch();
      int n_clr;
      if (m_phase == P_RUN) return 0;
      if (m_phase != P_REL) return (1 << N_CH) - 1;
      n_clr = m_el / STAGGER + 1;
      if (n_clr > N_CH) n_clr = N_CH;
      return ((1 << N_CH) - 1) & ~((1 << n_clr) - 1);
   endfunction

   task automatic m_enter(input int p);
      m_phase = p;
      m_el    = 0;
   endtask

   task automatic m_attempt_failed();
      int prior;
      prior = m_retry;
      if (m_retry < 255) m_retry++;
      if (MAX_RETRY != 0 && prior + 1 >= MAX_RETRY) begin
         m_fail = 1'b1;
         m_enter(P_FAIL);
      end else begin
         m_enter(P_RST);
      end
   endtask

   // Model advances on each clock edge; lock is seen two samples late.
   initial begin
      forever begin
         @(posedge clkin1 or posedge pll_rst);
         if (pll_rst) begin
            cyc      = 0;
            m_retry  = 0;
            m_fail   = 1'b0;
            lhist[0] = 1'b0;
            lhist[1] = 1'b0;
            m_enter(P_RST);
         end else begin
            bit ls;
            cyc++;
            ls       = lhist[1];
            lhist[1] = lhist[0];
            lhist[0] = pll_lock;
            if (restart) begin
               m_retry = 0;
               m_fail  = 1'b0;
               m_enter(P_RST);
            end else begin
               case (m_phase)
                  P_RST:    if (m_el + 1 >= RST_HOLD) m_enter(P_WAIT); else m_el++;
                  P_WAIT:   if (ls) m_enter(P_STABLE);
                            else if (m_el + 1 >= TIMEOUT) m_attempt_failed();
                            else m_el++;
                  P_STABLE: if (!ls) m_enter(P_WAIT);
                            else if (m_el + 1 >= STABLE_CYC) m_enter(P_GATE);
                            else m_el++;
                  P_GATE:   if (!ls) m_attempt_failed();
                            else if (m_el + 1 >= GATE_DLY) m_enter(P_REL);
                            else m_el++;
                  P_REL:    if (!ls) m_attempt_failed();
                            else if (m_el + 1 >= STAGGER * (N_CH - 1) + 1) m_enter(P_RUN);
                            else m_el++;
                  P_RUN:    if (!ls) m_attempt_failed();
                  default:  ;
               endcase
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clkin1);
         chk("state",    state_dbg,    m_phase);
         chk("core_rst", pll_core_rst, (m_phase == P_RST || m_phase == P_FAIL));
         chk("gate",     clkout0_gate, (m_phase == P_GATE || m_phase == P_REL || m_phase == P_RUN));
         chk("ch_rst",   ch_rst,       exp_ch());
         chk("ready",    ready,        (m_phase == P_RUN));
         chk("fail",     fail,         m_fail);
         chk("retry",    retry_cnt,    m_retry);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached (cyc=%0d)", cyc);
      $fatal(1, "watchdog");
   end

   task automatic goto(input int n);
      while (cyc < n) @(negedge clkin1);
   endtask

   task automatic wait_state(input int st, input int budget, input string what);
      int n;
      n = 0;
      while (state_dbg != st && n < budget) begin
         @(negedge clkin1);
         n++;
      end
      chk(what, state_dbg, st);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clkin1);
      restart = 1'b0;
   endtask

   initial begin
      int c;
      int s;
      #1 pll_rst = 1'b1;
      repeat (3) @(negedge clkin1);
      chk("rst_state", state_dbg, 0);
      chk("rst_core",  pll_core_rst, 1);
      chk("rst_ch",    ch_rst, 31);
      chk("rst_ready", ready, 0);
      pll_rst = 1'b0;

      // nominal bring-up; lock rises after 100 cycles
      goto(15);  chk("hold_core_15", pll_core_rst, 1);
      goto(16);  chk("hold_core_16", pll_core_rst, 0);
      chk("hold_state_16", state_dbg, 1);
      goto(100); pll_lock = 1'b1;
      goto(166); chk("gate_166", clkout0_gate, 0);
      goto(167); chk("gate_167", clkout0_gate, 1);
      chk("gate_state", state_dbg, 3);
      goto(174); chk("ch_174", ch_rst, 31);
      goto(175); chk("ch_175", ch_rst, 30);
      goto(179); chk("ch_179", ch_rst, 28);
      goto(191); chk("ch_191", ch_rst, 0);
      chk("ready_191", ready, 0);
      goto(192); chk("ready_192", ready, 1);
      chk("run_state", state_dbg, 5);

      // lock loss in RUN
      goto(220); pll_lock = 1'b0;
      goto(222); chk("loss_ready_222", ready, 1);
      goto(223);
      chk("loss_ready", ready, 0);
      chk("loss_ch",    ch_rst, 31);
      chk("loss_gate",  clkout0_gate, 0);
      chk("loss_retry", retry_cnt, 1);
      chk("loss_state", state_dbg, 0);
      goto(240); pll_lock = 1'b1;
      wait_state(P_RUN, 400, "relock_run");
      chk("relock_ready", ready, 1);
      chk("relock_retry", retry_cnt, 1);

      // restart coinciding with a lock-loss decision
      c = cyc;
      pll_lock = 1'b0;
      goto(c + 2); restart = 1'b1;
      goto(c + 3); restart = 1'b0;
      chk("rs_state", state_dbg, 0);
      chk("rs_retry", retry_cnt, 0);
      chk("rs_fail",  fail, 0);
      chk("rs_core",  pll_core_rst, 1);

      // one-cycle glitch 30 cycles into STABLE
      pll_lock = 1'b1;
      wait_state(P_STABLE, 300, "reach_stable");
      s = cyc;
      goto(s + 29); pll_lock = 1'b0;
      goto(s + 30); pll_lock = 1'b1;
      goto(s + 31); chk("gl_still_stable", state_dbg, 2);
      goto(s + 32); chk("gl_wait", state_dbg, 1);
      chk("gl_retry", retry_cnt, 0);
      goto(s + 33); chk("gl_restable", state_dbg, 2);
      goto(s + 96); chk("gl_gate_96", clkout0_gate, 0);
      goto(s + 97); chk("gl_gate_97", clkout0_gate, 1);

      // asynchronous reset in the middle of RELEASE
      wait_state(P_REL, 100, "reach_release");
      goto(cyc + 5);
      #2 pll_rst = 1'b1;
      #1;
      chk("arst_core",  pll_core_rst, 1);
      chk("arst_gate",  clkout0_gate, 0);
      chk("arst_ch",    ch_rst, 31);
      chk("arst_ready", ready, 0);
      chk("arst_state", state_dbg, 0);
      pll_lock = 1'b0;
      repeat (2) @(negedge clkin1);
      pll_rst = 1'b0;

      // lock never arrives: three timeouts then FAIL
      goto(647);
      chk("to_state_647", state_dbg, 1);
      chk("to_retry_647", retry_cnt, 2);
      chk("to_fail_647",  fail, 0);
      goto(648);
      chk("to_state", state_dbg, 6);
      chk("to_fail",  fail, 1);
      chk("to_retry", retry_cnt, 3);
      chk("to_core",  pll_core_rst, 1);
      chk("to_ch",    ch_rst, 31);
      goto(660);
      chk("fail_held", state_dbg, 6);
      pulse_restart();
      chk("fr_state", state_dbg, 0);
      chk("fr_fail",  fail, 0);
      chk("fr_retry", retry_cnt, 0);

      // randomized lock behaviour and restarts, checked by the model
      for (int seg = 0; seg < 50; seg++) begin
         pll_lock = 1'b1;
         repeat ($urandom_range(10, 260)) @(negedge clkin1);
         pll_lock = 1'b0;
         if ($urandom_range(0, 5) == 0)
            repeat ($urandom_range(150, 260)) @(negedge clkin1);
         else
            repeat ($urandom_range(1, 12)) @(negedge clkin1);
         if ($urandom_range(0, 7) == 0) pulse_restart();
      end
      pll_lock = 1'b1;
      repeat (5) @(negedge clkin1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
